// File: rtl/ip_video_timing.sv
// ip_video_timing
// ---------------------------------------------------------------------------
// Raster timing generator for the HDMI path. Two free-running counters
// (h_cnt, v_cnt) walk the raster with origin (0,0) at the first active pixel.
// Each line and each frame is laid out as active, front porch, sync, back porch.
// All outputs are decoded from the counters and then registered, so every
// output reflects the counter state of the previous enabled cycle.
//
// Ports:
//   clk         pixel clock
//   reset_n     asynchronous active-low reset
//   enable      1 = counters advance; 0 = counters and all outputs hold
//   video_de    data enable (registered)
//   video_hs    horizontal sync, active level HS_POL (registered)
//   video_vs    vertical sync, active level VS_POL (registered)
//   pixel_x     active column while video_de = 1, else 0
//   pixel_y     active line while video_de = 1, else 0
//   frame_start one-cycle pulse on the first DE cycle of a frame
//   fetch_req   one-cycle pulse PREFETCH clocks before an active line starts
//   fetch_line  line number belonging to the most recent fetch_req
// ---------------------------------------------------------------------------
module ip_video_timing #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int PREFETCH = 128
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic        video_de,
    output logic        video_hs,
    output logic        video_vs,
    output logic [10:0] pixel_x,
    output logic [9:0]  pixel_y,
    output logic        frame_start,
    output logic        fetch_req,
    output logic [9:0]  fetch_line
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] FETCH_H  = 11'(H_TOTAL - PREFETCH);

    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;

    logic        de_now;
    logic        hs_now;
    logic        vs_now;
    logic [9:0]  next_line;
    logic        fetch_now;

    // Combinational decode of the current counter state; everything here is
    // registered below so the outputs trail the counters by one enabled cycle.
    // VS depends only on v_cnt, so its edges fall on h_cnt = 0 (progressive).
    always_comb begin
        de_now    = 1'b0;
        hs_now    = 1'b0;
        vs_now    = 1'b0;
        next_line = '0;
        fetch_now = 1'b0;

        de_now    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_now    = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vs_now    = (v_cnt >= VS_START) && (v_cnt < VS_END);
        next_line = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        // The line-0 request lands on the last back-porch line because
        // next_line wraps to 0 there.
        fetch_now = (h_cnt == FETCH_H) && (next_line < V_ACT);
    end

    // Raster counters. v_cnt only moves when h_cnt wraps, so both wrap
    // together at the bottom-right corner of the frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (enable) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end
        end
    end

    // Registered outputs. Holding everything (pulses included) while enable
    // is low keeps pulses from repeating: the counters did not move, so the
    // same decode is simply held rather than re-issued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            video_de    <= 1'b0;
            video_hs    <= ~HS_POL;
            video_vs    <= ~VS_POL;
            pixel_x     <= '0;
            pixel_y     <= '0;
            frame_start <= 1'b0;
            fetch_req   <= 1'b0;
            fetch_line  <= '0;
        end else if (enable) begin
            video_de    <= de_now;
            video_hs    <= hs_now ? HS_POL : ~HS_POL;
            video_vs    <= vs_now ? VS_POL : ~VS_POL;
            pixel_x     <= de_now ? h_cnt : 11'd0;
            pixel_y     <= de_now ? v_cnt : 10'd0;
            frame_start <= (h_cnt == 11'd0) && (v_cnt == 10'd0);
            fetch_req   <= fetch_now;
            if (fetch_now) begin
                fetch_line <= next_line;
            end
        end
    end

endmodule

// File: tb/tb_ip_video_timing.sv
// tb_ip_video_timing
// ---------------------------------------------------------------------------
// Self-checking bench for ip_video_timing using a reduced raster so several
// whole frames fit in a short run. Enable is randomized; the reference model
// tracks only the count of enabled clock edges since reset and derives every
// expected output from that count with plain division/modulo arithmetic.
// ---------------------------------------------------------------------------
module tb_ip_video_timing;

    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 3;
    localparam int H_SYNC   = 4;
    localparam int H_BP     = 5;
    localparam int V_ACTIVE = 6;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int PREFETCH = 10;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        video_de;
    logic        video_hs;
    logic        video_vs;
    logic [10:0] pixel_x;
    logic [9:0]  pixel_y;
    logic        frame_start;
    logic        fetch_req;
    logic [9:0]  fetch_line;

    int checks;
    int errors;

    // Reference model state
    int edges;          // enabled clock edges since reset release
    int exp_fetch_line; // line of the latest expected fetch request
    int fetch_seen;     // fetch_req pulses observed on enabled edges
    int fetch_exp;      // fetch_req pulses the model expects

    ip_video_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(1'b1), .VS_POL(1'b1), .PREFETCH(PREFETCH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .video_de(video_de),
        .video_hs(video_hs),
        .video_vs(video_vs),
        .pixel_x(pixel_x),
        .pixel_y(pixel_y),
        .frame_start(frame_start),
        .fetch_req(fetch_req),
        .fetch_line(fetch_line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
        end
    endtask

    // Raster position reflected by the outputs after the given edge count.
    function automatic int pos_h(input int n);
        return (n - 1) % H_TOTAL;
    endfunction

    function automatic int pos_v(input int n);
        return ((n - 1) / H_TOTAL) % V_TOTAL;
    endfunction

    function automatic bit fetch_at(input int n);
        int nl;
        nl = (pos_v(n) + 1) % V_TOTAL;
        return (pos_h(n) == H_TOTAL - PREFETCH) && (nl < V_ACTIVE);
    endfunction

    // Compare every output against the model.
    task automatic checkAll(input string where);
        int h, v;
        bit de, hs, vs, fs, fr;
        if (edges == 0) begin
            de = 0; hs = 0; vs = 0; fs = 0; fr = 0; h = 0; v = 0;
        end else begin
            h  = pos_h(edges);
            v  = pos_v(edges);
            de = (h < H_ACTIVE) && (v < V_ACTIVE);
            hs = (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
            vs = (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
            fs = ((edges - 1) % (H_TOTAL * V_TOTAL)) == 0;
            fr = fetch_at(edges);
        end
        checkOutput({where, ".de"}, int'(video_de), int'(de));
        checkOutput({where, ".hs"}, int'(video_hs), int'(hs));
        checkOutput({where, ".vs"}, int'(video_vs), int'(vs));
        checkOutput({where, ".px"}, int'(pixel_x), de ? h : 0);
        checkOutput({where, ".py"}, int'(pixel_y), de ? v : 0);
        checkOutput({where, ".fs"}, int'(frame_start), int'(fs));
        checkOutput({where, ".freq"}, int'(fetch_req), int'(fr));
        checkOutput({where, ".fline"}, int'(fetch_line), exp_fetch_line);
    endtask

    // One clock: drive enable, advance the model on enabled edges, sample 1ns later.
    task automatic applyStimulus(input logic en, input string where);
        enable = en;
        @(posedge clk);
        if (en) begin
            edges++;
            if (fetch_at(edges)) begin
                exp_fetch_line = (pos_v(edges) + 1) % V_TOTAL;
                fetch_exp++;
            end
        end
        #1;
        if (en && fetch_req) fetch_seen++;
        checkAll(where);
    endtask

    task automatic model_reset();
        edges          = 0;
        exp_fetch_line = 0;
    endtask

    initial begin
        bit found;
        checks     = 0;
        errors     = 0;
        fetch_seen = 0;
        fetch_exp  = 0;
        model_reset();
        enable  = 1'b1;
        reset_n = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkAll("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // First enabled edge after release must show (0,0) with frame_start.
        applyStimulus(1'b1, "first");

        // Two clean frames with enable held high.
        for (int i = 0; i < 2 * H_TOTAL * V_TOTAL; i++) begin
            applyStimulus(1'b1, "run");
        end

        // Randomized enable, including a long stall mid-line.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, "rand");
        end
        for (int i = 0; i < 37; i++) begin
            applyStimulus(1'b0, "stall");
        end
        for (int i = 0; i < 2 * H_TOTAL; i++) begin
            applyStimulus(1'b1, "resume");
        end

        // Advance until HS is active, with a bounded search.
        found = 1'b0;
        for (int i = 0; i < 2 * H_TOTAL && !found; i++) begin
            applyStimulus(1'b1, "seekhs");
            if (pos_h(edges) == H_ACTIVE + H_FP + 1) found = 1'b1;
        end
        checkOutput("seek_hs_found", int'(found), 1);
        checkOutput("hs_before_reset", int'(video_hs), 1);

        // Asynchronous reset well away from any clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        checkAll("async");
        repeat (2) @(posedge clk);
        #1;
        checkAll("inreset");
        @(negedge clk);
        reset_n = 1'b1;

        applyStimulus(1'b1, "restart");
        for (int i = 0; i < H_TOTAL * V_TOTAL + 50; i++) begin
            applyStimulus(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, "rand2");
        end

        checkOutput("fetch_count", fetch_seen, fetch_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
